// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/sequencing controller:
// state encodings, default MUL latency and the control bundle type.
package pipeline_ctrl_pkg;

    localparam logic [1:0] PCTL_RUN       = 2'd0;
    localparam logic [1:0] PCTL_DMEM_WAIT = 2'd1;
    localparam logic [1:0] PCTL_MUL_WAIT  = 2'd2;
    localparam logic [1:0] PCTL_HALT      = 2'd3;

    localparam int unsigned PCTL_MUL_LATENCY = 4;

    // Wide enough for MUL_LATENCY-1 up to 15.
    localparam int unsigned MulCntW = 5;

    typedef enum logic [1:0] {
        StRun      = PCTL_RUN,
        StDmemWait = PCTL_DMEM_WAIT,
        StMulWait  = PCTL_MUL_WAIT,
        StHalt     = PCTL_HALT
    } pctl_state_e;

    typedef struct packed {
        logic en_pc;
        logic en_ifid;
        logic en_idex;
        logic en_exmem;
        logic en_memwb;
        logic bubble_idex;
        logic bubble_exmem;
        logic ex_mul_done;
    } pctl_ctrl_t;

    // Front end frozen while EX holds the MUL; MEM/WB drain with a bubble.
    function automatic pctl_ctrl_t mul_stall_ctrl();
        pctl_ctrl_t c;
        c              = '0;
        c.en_exmem     = 1'b1;
        c.en_memwb     = 1'b1;
        c.bubble_exmem = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/sequencing controller for the 5-stage pipeline: merges interlock, memory
// wait, multi-cycle MUL and debug halt into per-stage enables and bubble controls.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = PCTL_MUL_LATENCY,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt,
    input  logic             id_load_use,
    input  logic             ex_mul,
    input  logic             imem_ready,
    input  logic             ex_mem_req,
    input  logic             dmem_ready,
    output logic             en_pc,
    output logic             en_ifid,
    output logic             en_idex,
    output logic             en_exmem,
    output logic             en_memwb,
    output logic             bubble_idex,
    output logic             bubble_exmem,
    output logic             ex_mul_done,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cycles
);

    pctl_state_e        state_q, state_d;
    logic [MulCntW-1:0] mul_cnt_q, mul_cnt_d;
    pctl_ctrl_t         ctrl;
    logic               run_eval;
    logic               eff_req;
    logic               eff_mul;

    always_comb begin
        ctrl      = '0;
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        run_eval  = 1'b0;
        eff_req   = ex_mem_req;
        eff_mul   = ex_mul;

        unique case (state_q)
            StRun: begin
                run_eval = 1'b1;
            end
            StDmemWait: begin
                if (dmem_ready) begin
                    run_eval = 1'b1;
                    eff_req  = 1'b0;
                end
            end
            StMulWait: begin
                mul_cnt_d = mul_cnt_q - 1'b1;
                if (mul_cnt_q > MulCntW'(1)) begin
                    ctrl = mul_stall_ctrl();
                end else begin
                    // Last MUL cycle: MEM holds a bubble, so no memory request applies.
                    ctrl.ex_mul_done = 1'b1;
                    run_eval         = 1'b1;
                    eff_req          = 1'b0;
                    eff_mul          = 1'b0;
                end
            end
            StHalt: begin
                if (!halt) begin
                    state_d = StRun;
                end
            end
        endcase

        if (run_eval) begin
            state_d = StRun;
            if (eff_req && !dmem_ready) begin
                state_d = StDmemWait;
            end else if (halt) begin
                state_d = StHalt;
            end else if (eff_mul && (MUL_LATENCY > 1)) begin
                ctrl      = mul_stall_ctrl();
                state_d   = StMulWait;
                mul_cnt_d = MulCntW'(MUL_LATENCY - 1);
            end else if (!imem_ready) begin
                state_d = StRun;
            end else if (id_load_use) begin
                ctrl.en_idex     = 1'b1;
                ctrl.bubble_idex = 1'b1;
                ctrl.en_exmem    = 1'b1;
                ctrl.en_memwb    = 1'b1;
            end else begin
                ctrl.en_pc       = 1'b1;
                ctrl.en_ifid     = 1'b1;
                ctrl.en_idex     = 1'b1;
                ctrl.en_exmem    = 1'b1;
                ctrl.en_memwb    = 1'b1;
                ctrl.ex_mul_done = ctrl.ex_mul_done | eff_mul;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StRun;
            mul_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    // Reset freezes the pipeline immediately, independent of the clock.
    assign en_pc        = ctrl.en_pc & ~rst;
    assign en_ifid      = ctrl.en_ifid & ~rst;
    assign en_idex      = ctrl.en_idex & ~rst;
    assign en_exmem     = ctrl.en_exmem & ~rst;
    assign en_memwb     = ctrl.en_memwb & ~rst;
    assign bubble_idex  = ctrl.bubble_idex & ~rst;
    assign bubble_exmem = ctrl.bubble_exmem & ~rst;
    assign ex_mul_done  = ctrl.ex_mul_done & ~rst;
    assign ctrl_state   = state_q;

    sat_counter #(
        .Width(CNT_W)
    ) u_stall_cnt (
        .clk_i(clk),
        .rst_i(rst),
        .en_i (~en_pc & ~rst),
        .cnt_o(stall_cycles)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed and random checks of pipeline_ctrl against a stall-source model of
// the pipeline (MUL_LATENCY=4, narrow counter so saturation is reachable).
module tb_pipeline_ctrl;

    localparam int unsigned LAT  = 4;
    localparam int unsigned CW   = 6;
    localparam int          MAXC = (1 << CW) - 1;

    localparam logic [7:0] V_ALL  = 8'b1111_1000;
    localparam logic [7:0] V_MUL  = 8'b0001_1010;
    localparam logic [7:0] V_LU   = 8'b0011_1100;
    localparam logic [7:0] V_NONE = 8'b0000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          halt, id_load_use, ex_mul, imem_ready, ex_mem_req, dmem_ready;
    logic          en_pc, en_ifid, en_idex, en_exmem, en_memwb;
    logic          bubble_idex, bubble_exmem, ex_mul_done;
    logic [1:0]    ctrl_state;
    logic [CW-1:0] stall_cycles;
    logic [7:0]    dut_vec;

    int tests = 0;
    int fails = 0;

    // Model: what each stall source is currently doing.
    bit         m_dwait, m_halt, n_dwait, n_halt;
    int         m_mul_left, n_mul_left, m_stalls;
    logic [7:0] e_out;
    logic [1:0] e_state;

    pipeline_ctrl #(
        .MUL_LATENCY(LAT),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .halt        (halt),
        .id_load_use (id_load_use),
        .ex_mul      (ex_mul),
        .imem_ready  (imem_ready),
        .ex_mem_req  (ex_mem_req),
        .dmem_ready  (dmem_ready),
        .en_pc       (en_pc),
        .en_ifid     (en_ifid),
        .en_idex     (en_idex),
        .en_exmem    (en_exmem),
        .en_memwb    (en_memwb),
        .bubble_idex (bubble_idex),
        .bubble_exmem(bubble_exmem),
        .ex_mul_done (ex_mul_done),
        .ctrl_state  (ctrl_state),
        .stall_cycles(stall_cycles)
    );

    assign dut_vec = {en_pc, en_ifid, en_idex, en_exmem, en_memwb,
                      bubble_idex, bubble_exmem, ex_mul_done};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_dwait    = 0;
        m_halt     = 0;
        m_mul_left = 0;
        m_stalls   = 0;
    endtask

    task automatic model_eval();
        bit run, req, mul;
        e_out      = V_NONE;
        n_dwait    = m_dwait;
        n_halt     = m_halt;
        n_mul_left = m_mul_left;
        e_state    = m_halt ? 2'd3 : (m_mul_left > 0) ? 2'd2 : m_dwait ? 2'd1 : 2'd0;
        run        = 0;
        req        = ex_mem_req;
        mul        = ex_mul;
        if (m_halt) begin
            if (!halt) n_halt = 0;
        end else if (m_mul_left > 1) begin
            e_out      = V_MUL;
            n_mul_left = m_mul_left - 1;
        end else if (m_mul_left == 1) begin
            n_mul_left = 0;
            e_out[0]   = 1'b1;
            run        = 1;
            req        = 0;
            mul        = 0;
        end else if (m_dwait) begin
            if (dmem_ready) begin
                run     = 1;
                req     = 0;
                n_dwait = 0;
            end
        end else begin
            run = 1;
        end
        if (run) begin
            if (req && !dmem_ready) begin
                n_dwait = 1;
            end else if (halt) begin
                n_halt = 1;
            end else if (mul && LAT > 1) begin
                e_out      = V_MUL;
                n_mul_left = LAT - 1;
            end else if (!imem_ready) begin
                e_out = e_out & 8'h01;
            end else if (id_load_use) begin
                e_out = V_LU | (e_out & 8'h01);
            end else begin
                e_out = V_ALL | (e_out & 8'h01) | {7'd0, mul};
            end
        end
    endtask

    task automatic model_commit();
        m_dwait    = n_dwait;
        m_halt     = n_halt;
        m_mul_left = n_mul_left;
        if (!e_out[7] && m_stalls < MAXC) m_stalls++;
    endtask

    task automatic drive(input logic h, lu, mul, im, req, dr);
        halt        = h;
        id_load_use = lu;
        ex_mul      = mul;
        imem_ready  = im;
        ex_mem_req  = req;
        dmem_ready  = dr;
    endtask

    task automatic step(input logic h, lu, mul, im, req, dr, input string tag);
        @(negedge clk);
        drive(h, lu, mul, im, req, dr);
        #1;
        model_eval();
        check({tag, " outputs"}, 32'(dut_vec), 32'(e_out));
        check({tag, " state"}, 32'(ctrl_state), 32'(e_state));
        check({tag, " stall_cycles"}, 32'(stall_cycles), 32'(m_stalls));
        @(posedge clk);
        model_commit();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 1, 0, 1);
        #1;
        check("reset outputs", 32'(dut_vec), 32'(V_NONE));
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 1, 0, 1);
        model_reset();
        #2;
        check("init outputs", 32'(dut_vec), 32'(V_NONE));
        check("init state", 32'(ctrl_state), 32'd0);
        check("init stall_cycles", 32'(stall_cycles), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset asserted two cycles into MUL_WAIT takes effect without a clock edge.
        step(0, 0, 1, 1, 0, 1, "rmul c0");
        step(0, 0, 0, 1, 0, 1, "rmul c1");
        step(0, 0, 0, 1, 0, 1, "rmul c2");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async rst outputs", 32'(dut_vec), 32'(V_NONE));
        check("async rst state", 32'(ctrl_state), 32'd0);
        check("async rst stall_cycles", 32'(stall_cycles), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        model_eval();
        check("post-rst all enables", 32'(dut_vec), 32'(V_ALL));
        @(posedge clk);
        model_commit();

        // Single-cycle load-use interlock.
        do_reset();
        step(0, 1, 0, 1, 0, 1, "lu");
        #1;
        check("lu stall_cycles", 32'(stall_cycles), 32'd1);

        // Three-cycle data memory wait.
        do_reset();
        step(0, 0, 0, 1, 1, 0, "dw c0");
        step(0, 0, 0, 1, 1, 0, "dw c1");
        step(0, 0, 0, 1, 1, 0, "dw c2");
        step(0, 0, 0, 1, 1, 1, "dw c3");
        #1;
        check("dw stall_cycles", 32'(stall_cycles), 32'd3);

        // Back-to-back MULs.
        do_reset();
        step(0, 0, 1, 1, 0, 1, "mul c0");
        for (int i = 1; i < 4; i++) step(0, 0, 0, 1, 0, 1, "mul wait");
        #1;
        check("mul stall_cycles", 32'(stall_cycles), 32'd3);
        step(0, 0, 1, 1, 0, 1, "mul2 c4");
        for (int i = 5; i < 8; i++) step(0, 0, 0, 1, 0, 1, "mul2 wait");
        #1;
        check("mul2 stall_cycles", 32'(stall_cycles), 32'd6);

        // Halt raised during a data wait waits for the access to complete.
        do_reset();
        step(0, 0, 0, 1, 1, 0, "hd c0");
        step(1, 0, 0, 1, 1, 0, "hd c1");
        step(1, 0, 0, 1, 1, 0, "hd c2");
        step(1, 0, 0, 1, 1, 1, "hd c3");
        #1;
        check("hd halt entered", 32'(ctrl_state), 32'd3);
        step(1, 0, 0, 1, 0, 1, "hd c4");
        step(1, 0, 0, 1, 0, 1, "hd c5");
        step(0, 0, 0, 1, 0, 1, "hd c6");
        step(0, 0, 0, 1, 0, 1, "hd c7");

        // Saturation with simultaneous load-use and fetch wait.
        do_reset();
        for (int i = 0; i < MAXC + 4; i++) step(0, 0, 0, 0, 0, 1, "sat fill");
        step(0, 1, 0, 0, 0, 1, "sat lu+imem");
        #1;
        check("sat stall_cycles", 32'(stall_cycles), 32'(MAXC));

        // Random traffic.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i % 80 == 79) do_reset();
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
